// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the Game Boy T-cycle bus scheduler:
// phase and grant encodings, DMG lockout windows and the lockout predicate.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    PH_CPU    = 2'd0,
    PH_PPU    = 2'd1,
    PH_MEM    = 2'd2,
    PH_SETTLE = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_ISSUE = 2'd1,
    G_WAIT  = 2'd2,
    G_DONE  = 2'd3
  } grant_e;

  localparam logic [15:0] VRAM_LO = 16'h8000;
  localparam logic [15:0] VRAM_HI = 16'h9FFF;
  localparam logic [15:0] OAM_LO  = 16'hFE00;
  localparam logic [15:0] OAM_HI  = 16'hFE9F;

  localparam logic [1:0] PPU_MODE_OAM  = 2'd2;
  localparam logic [1:0] PPU_MODE_DRAW = 2'd3;

  // VRAM is closed while drawing; OAM is closed during OAM scan and drawing.
  function automatic logic cpu_addr_locked(input logic [15:0] addr, input logic [1:0] mode);
    logic in_vram;
    logic in_oam;
    in_vram = (addr >= VRAM_LO) && (addr <= VRAM_HI);
    in_oam  = (addr >= OAM_LO) && (addr <= OAM_HI);
    return (in_vram && (mode == PPU_MODE_DRAW)) ||
           (in_oam && ((mode == PPU_MODE_OAM) || (mode == PPU_MODE_DRAW)));
  endfunction

endpackage

// File: rtl/tcycle_phase_gen.sv
// Splits the system clock into four PHASE_LEN-clock phases per T-cycle and
// produces registered first-clock-of-phase flags (the CPU/PPU ones are the tick strobes).
module tcycle_phase_gen
  import gb_bus_pkg::*;
#(
  parameter int PHASE_LEN = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [1:0] phase_out,
  output logic       cpu_tclk_out,
  output logic       ppu_tclk_out,
  output logic       mem_first_out,
  output logic       settle_first_out
);

  localparam int SUB_W = $clog2(PHASE_LEN);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(PHASE_LEN - 1);

  logic [SUB_W-1:0] sub_cnt;
  phase_e           phase;
  logic             started;
  logic             wrap;

  assign wrap      = (sub_cnt == SUB_MAX);
  assign phase_out = phase;

  // The first clock after reset release is position 0 of a CPU phase, so the
  // counter holds there once while the CPU strobe is raised.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sub_cnt          <= '0;
      phase            <= PH_CPU;
      started          <= 1'b0;
      cpu_tclk_out     <= 1'b0;
      ppu_tclk_out     <= 1'b0;
      mem_first_out    <= 1'b0;
      settle_first_out <= 1'b0;
    end else if (!started) begin
      started          <= 1'b1;
      cpu_tclk_out     <= 1'b1;
      ppu_tclk_out     <= 1'b0;
      mem_first_out    <= 1'b0;
      settle_first_out <= 1'b0;
    end else begin
      if (wrap) begin
        sub_cnt <= '0;
        phase   <= phase_e'(phase + 2'd1);
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
      cpu_tclk_out     <= wrap && (phase == PH_SETTLE);
      ppu_tclk_out     <= wrap && (phase == PH_CPU);
      mem_first_out    <= wrap && (phase == PH_PPU);
      settle_first_out <= wrap && (phase == PH_MEM);
    end
  end

endmodule

// File: rtl/tcycle_bus_scheduler.sv
// T-cycle bus scheduler: one shared-memory access per T-cycle, PPU first, with DMG
// VRAM/OAM lockout. Decisions taken on a phase's first clock appear on the following clock.
module tcycle_bus_scheduler
  import gb_bus_pkg::*;
#(
  parameter int PHASE_LEN = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [1:0]  phase_out,
  output logic        cpu_tclk_out,
  output logic        ppu_tclk_out,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_addr_valid_in,
  input  logic        cpu_we_in,
  input  logic [7:0]  cpu_wdata_in,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_addr_valid_in,
  input  logic [1:0]  ppu_mode_in,
  output logic [15:0] mem_addr_out,
  output logic [7:0]  mem_wdata_out,
  output logic        mem_we_out,
  output logic        mem_req_out,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_data_valid_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_valid_out,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  output logic        cpu_stall_out,
  output logic        timeout_out
);

  logic   mem_first;
  logic   settle_first;
  grant_e state;
  logic   owner_ppu;
  logic   cpu_lock;
  logic   resp_fire;
  logic [7:0] resp_data;

  tcycle_phase_gen #(
    .PHASE_LEN(PHASE_LEN)
  ) u_phase_gen (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .phase_out       (phase_out),
    .cpu_tclk_out    (cpu_tclk_out),
    .ppu_tclk_out    (ppu_tclk_out),
    .mem_first_out   (mem_first),
    .settle_first_out(settle_first)
  );

  assign cpu_lock = cpu_addr_locked(cpu_addr_in, ppu_mode_in);

  // A silent memory is answered with open-bus 0xFF once SETTLE begins.
  assign resp_fire = mem_data_valid_in || settle_first;
  assign resp_data = mem_data_valid_in ? mem_data_in : 8'hFF;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= G_IDLE;
      owner_ppu          <= 1'b0;
      mem_addr_out       <= '0;
      mem_wdata_out      <= '0;
      mem_we_out         <= 1'b0;
      mem_req_out        <= 1'b0;
      cpu_data_out       <= '0;
      cpu_data_valid_out <= 1'b0;
      ppu_data_out       <= '0;
      ppu_data_valid_out <= 1'b0;
      cpu_stall_out      <= 1'b0;
      timeout_out        <= 1'b0;
    end else begin
      cpu_data_valid_out <= 1'b0;
      ppu_data_valid_out <= 1'b0;
      timeout_out        <= 1'b0;
      if (cpu_tclk_out) cpu_stall_out <= 1'b0;

      case (state)
        G_IDLE: begin
          if (mem_first) begin
            if (ppu_addr_valid_in) begin
              owner_ppu    <= 1'b1;
              mem_addr_out <= ppu_addr_in;
              mem_we_out   <= 1'b0;
              mem_req_out  <= 1'b1;
              state        <= G_ISSUE;
              // A locked CPU access does not need the port, so it still gets its answer.
              if (cpu_addr_valid_in && !cpu_lock) begin
                cpu_stall_out <= 1'b1;
              end else if (cpu_addr_valid_in && !cpu_we_in) begin
                cpu_data_out       <= 8'hFF;
                cpu_data_valid_out <= 1'b1;
              end
            end else if (cpu_addr_valid_in) begin
              if (cpu_lock) begin
                if (!cpu_we_in) begin
                  cpu_data_out       <= 8'hFF;
                  cpu_data_valid_out <= 1'b1;
                end
                state <= G_DONE;
              end else begin
                owner_ppu     <= 1'b0;
                mem_addr_out  <= cpu_addr_in;
                mem_wdata_out <= cpu_wdata_in;
                mem_we_out    <= cpu_we_in;
                mem_req_out   <= 1'b1;
                state         <= G_ISSUE;
              end
            end
          end
        end
        G_ISSUE: begin
          mem_req_out <= 1'b0;
          mem_we_out  <= 1'b0;
          state       <= mem_we_out ? G_DONE : G_WAIT;
        end
        G_WAIT: begin
          if (resp_fire) begin
            if (owner_ppu) begin
              ppu_data_out       <= resp_data;
              ppu_data_valid_out <= 1'b1;
            end else begin
              cpu_data_out       <= resp_data;
              cpu_data_valid_out <= 1'b1;
            end
            timeout_out <= !mem_data_valid_in;
            state       <= G_DONE;
          end
        end
        G_DONE: begin
          if (cpu_tclk_out) state <= G_IDLE;
        end
        default: state <= G_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcycle_bus_scheduler.sv
// Directed bench for tcycle_bus_scheduler with PHASE_LEN=8; cycle k counts clocks
// after reset release, cycle 0 being the first CPU strobe.
module tb_tcycle_bus_scheduler;

  localparam int PL = 8;
  localparam int SAMPLE_VIS = 2 * PL + 1;
  localparam int SETTLE_VIS = 3 * PL + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  phase;
  logic        cpu_tclk, ppu_tclk;
  logic [15:0] cpu_addr = '0;
  logic        cpu_valid = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [15:0] ppu_addr = '0;
  logic        ppu_valid = 1'b0;
  logic [1:0]  ppu_mode = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req;
  logic [7:0]  mem_data = '0;
  logic        mem_valid = 1'b0;
  logic [7:0]  cpu_data, ppu_data;
  logic        cpu_dv, ppu_dv, stall, timeout;

  int checks = 0;
  int errors = 0;
  int pos = 0;

  logic [15:0] lk_addr   [11] = '{16'h8100, 16'hFE10, 16'hFE10, 16'h9FFF, 16'hA000, 16'h7FFF,
                                  16'h8000, 16'hFE9F, 16'hFEA0, 16'hFE00, 16'h8000};
  logic [1:0]  lk_mode   [11] = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
  logic        lk_we     [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        lk_locked [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  tcycle_bus_scheduler #(.PHASE_LEN(PL)) dut (
    .clk_in(clk), .rst_in(rst), .phase_out(phase),
    .cpu_tclk_out(cpu_tclk), .ppu_tclk_out(ppu_tclk),
    .cpu_addr_in(cpu_addr), .cpu_addr_valid_in(cpu_valid), .cpu_we_in(cpu_we),
    .cpu_wdata_in(cpu_wdata), .ppu_addr_in(ppu_addr), .ppu_addr_valid_in(ppu_valid),
    .ppu_mode_in(ppu_mode), .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .mem_we_out(mem_we), .mem_req_out(mem_req), .mem_data_in(mem_data),
    .mem_data_valid_in(mem_valid), .cpu_data_out(cpu_data), .cpu_data_valid_out(cpu_dv),
    .ppu_data_out(ppu_data), .ppu_data_valid_out(ppu_dv), .cpu_stall_out(stall),
    .timeout_out(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pos++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_addr = '0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    ppu_addr = '0; ppu_valid = 1'b0; ppu_mode = '0; mem_data = '0; mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pos = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_addr = 16'hC000; cpu_valid = 1'b1; ppu_addr = 16'h8000; ppu_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({phase, cpu_tclk, ppu_tclk} !== 4'b0) begin
      errors++; $display("FAIL reset_phase: got %b expected 0000", {phase, cpu_tclk, ppu_tclk});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_req} !== 26'b0) begin
      errors++; $display("FAIL reset_mem: got %h/%h/%b/%b expected zero", mem_addr, mem_wdata, mem_we, mem_req);
    end
    checks++;
    if ({cpu_data, cpu_dv, ppu_data, ppu_dv} !== 18'b0) begin
      errors++; $display("FAIL reset_resp: got %h/%b/%h/%b expected zero", cpu_data, cpu_dv, ppu_data, ppu_dv);
    end
    checks++;
    if ({stall, timeout} !== 2'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {stall, timeout});
    end
    cpu_valid = 1'b0; ppu_valid = 1'b0;
  endtask

  task automatic test_phase_seq();
    logic [1:0] exp_phase;
    logic exp_c, exp_p;
    apply_reset();
    for (int k = 0; k < 64; k++) begin
      step();
      exp_phase = 2'((k / PL) % 4);
      exp_c = ((k % (4 * PL)) == 0);
      exp_p = ((k % (4 * PL)) == PL);
      checks++;
      if (phase !== exp_phase) begin
        errors++; $display("FAIL phase c%0d: got %0d expected %0d", k, phase, exp_phase);
      end
      checks++;
      if (cpu_tclk !== exp_c) begin
        errors++; $display("FAIL cpu_tclk c%0d: got %b expected %b", k, cpu_tclk, exp_c);
      end
      checks++;
      if (ppu_tclk !== exp_p) begin
        errors++; $display("FAIL ppu_tclk c%0d: got %b expected %b", k, ppu_tclk, exp_p);
      end
    end
  endtask

  task automatic test_cpu_read();
    int req_n = 0, req_cyc = -1, vld_n = 0, vld_cyc = -1, stall_n = 0, resp_at = -1;
    logic [15:0] req_addr = '0;
    logic req_we = 1'b0;
    logic [7:0] vld_data = '0;
    apply_reset();
    cpu_addr = 16'hC000; cpu_valid = 1'b1; cpu_we = 1'b0; ppu_mode = 2'd0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (mem_req) begin req_n++; req_cyc = k; req_addr = mem_addr; req_we = mem_we; resp_at = k + 2; end
      if (cpu_dv) begin vld_n++; vld_cyc = k; vld_data = cpu_data; cpu_valid = 1'b0; end
      if (stall) stall_n++;
      mem_valid = 1'b0;
      if (k == resp_at) begin mem_valid = 1'b1; mem_data = 8'h5A; end
    end
    checks++;
    if (req_n != 1 || req_cyc != SAMPLE_VIS) begin
      errors++; $display("FAIL rd_req: got %0d reqs at c%0d expected 1 at c%0d", req_n, req_cyc, SAMPLE_VIS);
    end
    checks++;
    if (req_addr !== 16'hC000 || req_we !== 1'b0) begin
      errors++; $display("FAIL rd_addr: got %h we=%b expected C000 we=0", req_addr, req_we);
    end
    checks++;
    if (vld_n != 1 || vld_cyc != SAMPLE_VIS + 3) begin
      errors++; $display("FAIL rd_valid: got %0d at c%0d expected 1 at c%0d", vld_n, vld_cyc, SAMPLE_VIS + 3);
    end
    checks++;
    if (vld_data !== 8'h5A) begin
      errors++; $display("FAIL rd_data: got %h expected 5a", vld_data);
    end
    checks++;
    if (stall_n != 0) begin
      errors++; $display("FAIL rd_stall: got %0d stall clocks expected 0", stall_n);
    end
  endtask

  task automatic test_contention();
    int req_n = 0, resp_at = -1, p_cyc = -1, c_cyc = -1, p_n = 0, c_n = 0;
    int req_cyc [2] = '{-1, -1};
    logic [15:0] req_a [2] = '{16'h0, 16'h0};
    logic [15:0] last_a = '0;
    logic [7:0] p_data = '0, c_data = '0;
    logic exp_stall;
    apply_reset();
    ppu_addr = 16'h9800; ppu_valid = 1'b1; cpu_addr = 16'hC010; cpu_valid = 1'b1; cpu_we = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (mem_req) begin
        if (req_n < 2) begin req_cyc[req_n] = k; req_a[req_n] = mem_addr; end
        req_n++; last_a = mem_addr; resp_at = k + 1;
      end
      if (ppu_dv) begin p_n++; p_cyc = k; p_data = ppu_data; ppu_valid = 1'b0; end
      if (cpu_dv) begin c_n++; c_cyc = k; c_data = cpu_data; cpu_valid = 1'b0; end
      exp_stall = (k >= SAMPLE_VIS) && (k <= 4 * PL);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL cont_stall c%0d: got %b expected %b", k, stall, exp_stall);
      end
      mem_valid = 1'b0;
      if (k == resp_at) begin mem_valid = 1'b1; mem_data = last_a[7:0] ^ 8'h3C; end
    end
    checks++;
    if (req_n != 2 || req_cyc[0] != SAMPLE_VIS || req_cyc[1] != SAMPLE_VIS + 4 * PL) begin
      errors++; $display("FAIL cont_req: got %0d reqs at c%0d,c%0d expected 2 at c%0d,c%0d",
                         req_n, req_cyc[0], req_cyc[1], SAMPLE_VIS, SAMPLE_VIS + 4 * PL);
    end
    checks++;
    if (req_a[0] !== 16'h9800 || req_a[1] !== 16'hC010) begin
      errors++; $display("FAIL cont_addr: got %h,%h expected 9800,c010", req_a[0], req_a[1]);
    end
    checks++;
    if (p_n != 1 || p_cyc != SAMPLE_VIS + 2 || p_data !== 8'h3C) begin
      errors++; $display("FAIL cont_ppu: got %0d at c%0d data %h expected 1 at c%0d data 3c",
                         p_n, p_cyc, p_data, SAMPLE_VIS + 2);
    end
    checks++;
    if (c_n != 1 || c_cyc != SAMPLE_VIS + 4 * PL + 2 || c_data !== 8'h2C) begin
      errors++; $display("FAIL cont_cpu: got %0d at c%0d data %h expected 1 at c%0d data 2c",
                         c_n, c_cyc, c_data, SAMPLE_VIS + 4 * PL + 2);
    end
  endtask

  task automatic test_lockout();
    int req_n, req_cyc, vld_n, vld_cyc;
    logic [15:0] req_addr;
    logic req_we;
    logic [7:0] req_wd, vld_data, wd;
    for (int i = 0; i < 11; i++) begin
      req_n = 0; req_cyc = -1; vld_n = 0; vld_cyc = -1;
      req_addr = '0; req_we = 1'b0; req_wd = '0; vld_data = '0;
      wd = 8'hA5 ^ 8'(i);
      apply_reset();
      cpu_addr = lk_addr[i]; cpu_we = lk_we[i]; cpu_wdata = wd; ppu_mode = lk_mode[i]; cpu_valid = 1'b1;
      for (int k = 0; k < 24; k++) begin
        step();
        if (mem_req) begin
          req_n++; req_cyc = k; req_addr = mem_addr; req_we = mem_we; req_wd = mem_wdata; cpu_valid = 1'b0;
        end
        if (cpu_dv) begin vld_n++; vld_cyc = k; vld_data = cpu_data; cpu_valid = 1'b0; end
      end
      if (lk_locked[i]) begin
        checks++;
        if (req_n != 0) begin
          errors++; $display("FAIL lock%0d_noreq: addr %h mode %0d got %0d reqs expected 0", i, lk_addr[i], lk_mode[i], req_n);
        end
        checks++;
        if (lk_we[i] ? (vld_n != 0)
                     : (vld_n != 1 || vld_cyc != SAMPLE_VIS || vld_data !== 8'hFF)) begin
          errors++; $display("FAIL lock%0d_resp: got %0d valids at c%0d data %h expected %0d at c%0d data ff",
                             i, vld_n, vld_cyc, vld_data, lk_we[i] ? 0 : 1, SAMPLE_VIS);
        end
      end else begin
        checks++;
        if (req_n != 1 || req_cyc != SAMPLE_VIS || req_addr !== lk_addr[i] || req_we !== lk_we[i]) begin
          errors++; $display("FAIL unlock%0d_req: got %0d reqs c%0d addr %h we %b expected 1 c%0d addr %h we %b",
                             i, req_n, req_cyc, req_addr, req_we, SAMPLE_VIS, lk_addr[i], lk_we[i]);
        end
        checks++;
        if (vld_n != 0 || (lk_we[i] && req_wd !== wd)) begin
          errors++; $display("FAIL unlock%0d_data: got %0d valids wdata %h expected 0 valids wdata %h", i, vld_n, req_wd, wd);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w_cyc = -1, r_cyc = -1, req_n = 0, vld_cyc = -1, resp_at = -1;
    logic [7:0] w_data = '0, r_data = '0;
    apply_reset();
    cpu_addr = 16'hC123; cpu_we = 1'b1; cpu_wdata = 8'h3C; cpu_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (mem_req) begin
        req_n++;
        if (mem_we) begin w_cyc = k; w_data = mem_wdata; cpu_addr = 16'hC124; cpu_we = 1'b0; end
        else begin r_cyc = k; resp_at = k + 1; end
      end
      if (cpu_dv) begin vld_cyc = k; r_data = cpu_data; cpu_valid = 1'b0; end
      mem_valid = 1'b0;
      if (k == resp_at) begin mem_valid = 1'b1; mem_data = 8'hC3; end
    end
    checks++;
    if (req_n != 2 || w_cyc != SAMPLE_VIS || w_data !== 8'h3C) begin
      errors++; $display("FAIL b2b_write: got %0d reqs write c%0d data %h expected 2, c%0d, 3c", req_n, w_cyc, w_data, SAMPLE_VIS);
    end
    checks++;
    if (r_cyc != SAMPLE_VIS + 4 * PL || vld_cyc != SAMPLE_VIS + 4 * PL + 2 || r_data !== 8'hC3) begin
      errors++; $display("FAIL b2b_read: got req c%0d valid c%0d data %h expected c%0d c%0d c3",
                         r_cyc, vld_cyc, r_data, SAMPLE_VIS + 4 * PL, SAMPLE_VIS + 4 * PL + 2);
    end
  endtask

  task automatic test_timeout();
    int req_cyc = -1, to_n = 0, to_cyc = -1, p_n = 0, p_cyc = -1, c_n = 0;
    logic [7:0] p_data = '0;
    apply_reset();
    ppu_addr = 16'h8000; ppu_valid = 1'b1; ppu_mode = 2'd3;
    for (int k = 0; k < 48; k++) begin
      step();
      if (mem_req) begin req_cyc = k; ppu_valid = 1'b0; end
      if (timeout) begin to_n++; to_cyc = k; end
      if (ppu_dv) begin p_n++; p_cyc = k; p_data = ppu_data; end
      if (cpu_dv) c_n++;
      mem_valid = 1'b0;
      if (k == SETTLE_VIS + 2) begin mem_valid = 1'b1; mem_data = 8'h11; end
    end
    checks++;
    if (req_cyc != SAMPLE_VIS) begin
      errors++; $display("FAIL to_req: got c%0d expected c%0d", req_cyc, SAMPLE_VIS);
    end
    checks++;
    if (to_n != 1 || to_cyc != SETTLE_VIS) begin
      errors++; $display("FAIL to_pulse: got %0d at c%0d expected 1 at c%0d", to_n, to_cyc, SETTLE_VIS);
    end
    checks++;
    if (p_n != 1 || p_cyc != SETTLE_VIS || p_data !== 8'hFF || c_n != 0) begin
      errors++; $display("FAIL to_resp: got %0d ppu at c%0d data %h, %0d cpu expected 1 at c%0d data ff, 0",
                         p_n, p_cyc, p_data, c_n, SETTLE_VIS);
    end
  endtask

  task automatic test_reset_mid_op();
    int bad_n = 0, c0 = 0;
    apply_reset();
    ppu_addr = 16'h8000; ppu_valid = 1'b1;
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1; ppu_valid = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_data = 8'h77;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase, cpu_tclk, ppu_tclk, mem_req, mem_we, cpu_dv, ppu_dv, stall, timeout} !== 10'b0) begin
      errors++; $display("FAIL rmid_ctrl: got %b expected all zero",
                         {phase, cpu_tclk, ppu_tclk, mem_req, mem_we, cpu_dv, ppu_dv, stall, timeout});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_data, ppu_data} !== 40'b0) begin
      errors++; $display("FAIL rmid_data: got %h/%h/%h/%h expected zero", mem_addr, mem_wdata, cpu_data, ppu_data);
    end
    rst = 1'b0; pos = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 0) c0 = int'(cpu_tclk);
      if (mem_req || cpu_dv || ppu_dv || timeout || stall) bad_n++;
      mem_valid = (k == 3);
      mem_data = 8'h77;
    end
    mem_valid = 1'b0;
    checks++;
    if (bad_n != 0) begin
      errors++; $display("FAIL rmid_quiet: got %0d active clocks expected 0", bad_n);
    end
    checks++;
    if (c0 != 1) begin
      errors++; $display("FAIL rmid_restart: cpu_tclk at c0 got %0d expected 1", c0);
    end
  endtask

  initial begin
    test_reset();
    test_phase_seq();
    test_cpu_read();
    test_contention();
    test_lockout();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
